// File: rtl/sinogram_lane_addresser_if.sv
// Host / filtered-RAM / sinogram-RAM signal bundle for sinogram_lane_addresser.
// Host side:   hs_kick, hs_start, hs_count, hs_reverse -> ; <- hs_done, hs_err, hs_busy
// Filtered RAM: fr_s_val, fr_next_angle -> ; <- fr_angle, fr_has_next_angle, fr_next_angle_ack
// Sinogram RAM: <- sg_addr (lane k in [k*ADDR_WIDTH +: ADDR_WIDTH]), sg_lane_valid
// master drives the requests (host / filtered RAM side); slave is the addresser.
interface sinogram_lane_addresser_if #(
  parameter int unsigned ANGLE_WIDTH = 8,
  parameter int unsigned S_WIDTH     = 4,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned LANES       = 2
);
  logic                          hs_kick;
  logic [ANGLE_WIDTH-1:0]        hs_start;
  logic [ANGLE_WIDTH-1:0]        hs_count;
  logic                          hs_reverse;
  logic                          hs_done;
  logic                          hs_err;
  logic                          hs_busy;
  logic [S_WIDTH-1:0]            fr_s_val;
  logic                          fr_next_angle;
  logic [ANGLE_WIDTH-1:0]        fr_angle;
  logic                          fr_has_next_angle;
  logic                          fr_next_angle_ack;
  logic [LANES*ADDR_WIDTH-1:0]   sg_addr;
  logic [LANES-1:0]              sg_lane_valid;

  modport master (
    output hs_kick, hs_start, hs_count, hs_reverse, fr_s_val, fr_next_angle,
    input  hs_done, hs_err, hs_busy, fr_angle, fr_has_next_angle, fr_next_angle_ack,
           sg_addr, sg_lane_valid
  );

  modport slave (
    input  hs_kick, hs_start, hs_count, hs_reverse, fr_s_val, fr_next_angle,
    output hs_done, hs_err, hs_busy, fr_angle, fr_has_next_angle, fr_next_angle_ack,
           sg_addr, sg_lane_valid
  );
endinterface

// File: rtl/sinogram_lane_addresser.sv
// Walks a host-configured window of projection angles (forward or reverse),
// LANES angles per step, and produces one registered sinogram RAM address per
// lane from the shared filtered-RAM s value.
// Ports: clk, reset_n (async active-low), bus (slave side of
// sinogram_lane_addresser_if: host kick/config/status, filtered-RAM angle
// handshake, per-lane sinogram addresses with valid flags).
module sinogram_lane_addresser #(
  parameter int unsigned NO_OF_ANGLES = 12,
  parameter int unsigned LINE_SIZE    = 16,
  parameter int unsigned LANES        = 2,
  parameter int unsigned ANGLE_STEP   = 15,
  parameter int unsigned ANGLE_WIDTH  = 8,
  parameter int unsigned S_WIDTH      = 4,
  parameter int unsigned ADDR_WIDTH   = 8
) (
  input logic                        clk,
  input logic                        reset_n,
  sinogram_lane_addresser_if.slave   bus
);

  localparam int unsigned AW = ANGLE_WIDTH;
  localparam int unsigned DW = ADDR_WIDTH;
  localparam int unsigned EW = ANGLE_WIDTH + 1;

  // Per-step increments, all compile-time constants.
  localparam logic [AW-1:0] IDX_INC   = AW'(LANES);
  localparam logic [AW-1:0] ANGLE_INC = AW'(LANES * ANGLE_STEP);
  localparam logic [DW-1:0] BASE_INC  = DW'(LANES * LINE_SIZE);

  typedef enum logic {
    READY = 1'b0,
    WORK  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    dir_q, dir_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [AW-1:0]           rem_q, rem_d;
  logic [AW-1:0]           angle_q, angle_d;
  logic [DW-1:0]           base_q, base_d;
  logic                    err_q, err_d;
  logic [LANES*DW-1:0]     addr_q, addr_d;
  logic [LANES-1:0]        valid_q, valid_d;

  logic [S_WIDTH-1:0]      s_val;
  logic [EW-1:0]           win_end;
  logic                    cfg_bad;
  logic [AW-1:0]           kick_idx;
  logic                    has_next;
  logic                    ack;
  logic                    done;

  assign s_val    = bus.fr_s_val;
  // Window end computed one bit wider so start+count cannot overflow the check.
  assign win_end  = {1'b0, bus.hs_start} + {1'b0, bus.hs_count};
  assign cfg_bad  = (bus.hs_count == '0) || (win_end > EW'(NO_OF_ANGLES));
  assign kick_idx = bus.hs_reverse ? AW'(win_end - EW'(1)) : bus.hs_start;

  assign has_next = (state_q == WORK) && (rem_q > AW'(LANES));
  assign ack      = (state_q == WORK) && bus.fr_next_angle && has_next;
  assign done     = (state_q == WORK) && bus.fr_next_angle && !has_next;

  // State and walk registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= READY;
      dir_q   <= 1'b0;
      idx_q   <= '0;
      rem_q   <= '0;
      angle_q <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      angle_q <= angle_d;
      base_q  <= base_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  // Next state: kick accept/reject in READY, accumulator stepping in WORK.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    angle_d = angle_q;
    base_d  = base_q;
    err_d   = 1'b0;
    case (state_q)
      READY: begin
        if (bus.hs_kick) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = WORK;
            dir_d   = bus.hs_reverse;
            rem_d   = bus.hs_count;
            idx_d   = kick_idx;
            // One-off constant-coefficient products at window start only.
            base_d  = DW'(kick_idx) * DW'(LINE_SIZE);
            angle_d = kick_idx * AW'(ANGLE_STEP);
          end
        end
      end
      WORK: begin
        if (ack) begin
          rem_d = rem_q - IDX_INC;
          if (dir_q) begin
            idx_d   = idx_q - IDX_INC;
            base_d  = base_q - BASE_INC;
            angle_d = angle_q - ANGLE_INC;
          end else begin
            idx_d   = idx_q + IDX_INC;
            base_d  = base_q + BASE_INC;
            angle_d = angle_q + ANGLE_INC;
          end
        end else if (done) begin
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  // Per-lane address: base +/- constant lane offset + s; invalid lanes read 0.
  always_comb begin
    addr_d  = '0;
    valid_d = '0;
    if (state_q == WORK) begin
      for (int k = 0; k < int'(LANES); k++) begin
        if (AW'(k) < rem_q) begin
          valid_d[k] = 1'b1;
          if (dir_q) begin
            addr_d[k*DW +: DW] = base_q - DW'(k * LINE_SIZE) + DW'(s_val);
          end else begin
            addr_d[k*DW +: DW] = base_q + DW'(k * LINE_SIZE) + DW'(s_val);
          end
        end
      end
    end
  end

  assign bus.hs_done           = done;
  assign bus.hs_err            = err_q;
  assign bus.hs_busy           = (state_q == WORK);
  assign bus.fr_angle          = angle_q;
  assign bus.fr_has_next_angle = has_next;
  assign bus.fr_next_angle_ack = ack;
  assign bus.sg_addr           = addr_q;
  assign bus.sg_lane_valid     = valid_q;

endmodule

// File: tb/tb_sinogram_lane_addresser.sv
// Directed, cycle-accurate bench for sinogram_lane_addresser (default params).
// Each table row is one clock cycle: inputs driven just after posedge, all
// outputs compared at the following negedge.
module tb_sinogram_lane_addresser;

  localparam int unsigned AW = 8;
  localparam int unsigned SW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned LN = 2;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  sinogram_lane_addresser_if #(
    .ANGLE_WIDTH(AW), .S_WIDTH(SW), .ADDR_WIDTH(DW), .LANES(LN)
  ) bus ();

  sinogram_lane_addresser #(
    .NO_OF_ANGLES(12), .LINE_SIZE(16), .LANES(LN), .ANGLE_STEP(15),
    .ANGLE_WIDTH(AW), .S_WIDTH(SW), .ADDR_WIDTH(DW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic       kick;
    logic [7:0] start;
    logic [7:0] count;
    logic       rev;
    logic [3:0] s;
    logic       nxt;
    logic       busy;
    logic       has_next;
    logic       ack;
    logic       done;
    logic       err;
    logic [7:0] ang;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [1:0] vld;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, id, act, exp);
    end
  endtask

  task automatic add(input logic kick, input int start, input int count, input logic rev,
                     input int s, input logic nxt, input logic busy, input logic hn,
                     input logic ack, input logic done, input logic err, input int ang,
                     input int a0, input int a1, input int vld);
    vec_t v;
    v.kick = kick; v.start = 8'(start); v.count = 8'(count); v.rev = rev;
    v.s = 4'(s); v.nxt = nxt; v.busy = busy; v.has_next = hn; v.ack = ack;
    v.done = done; v.err = err; v.ang = 8'(ang); v.a0 = 8'(a0); v.a1 = 8'(a1);
    v.vld = 2'(vld);
    vecs.push_back(v);
  endtask

  task automatic drive(input logic kick, input int start, input int count, input logic rev,
                       input int s, input logic nxt);
    bus.hs_kick       = kick;
    bus.hs_start      = 8'(start);
    bus.hs_count      = 8'(count);
    bus.hs_reverse    = rev;
    bus.fr_s_val      = 4'(s);
    bus.fr_next_angle = nxt;
  endtask

  task automatic check_outs(input int id, input logic busy, input logic hn, input logic ack,
                            input logic done, input logic err, input int ang, input int a0,
                            input int a1, input int vld);
    chk("hs_busy", id, 32'(bus.hs_busy), 32'(busy));
    chk("has_next", id, 32'(bus.fr_has_next_angle), 32'(hn));
    chk("ack", id, 32'(bus.fr_next_angle_ack), 32'(ack));
    chk("hs_done", id, 32'(bus.hs_done), 32'(done));
    chk("hs_err", id, 32'(bus.hs_err), 32'(err));
    chk("fr_angle", id, 32'(bus.fr_angle), 32'(ang));
    chk("lane0_addr", id, 32'(bus.sg_addr[7:0]), 32'(a0));
    chk("lane1_addr", id, 32'(bus.sg_addr[15:8]), 32'(a1));
    chk("lane_valid", id, 32'(bus.sg_lane_valid), 32'(vld));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // kick start cnt rev s nxt | busy hn ack done err ang a0 a1 vld
    // Forward full window, s=3.
    add(1, 0, 12, 0, 3, 0,  0, 0, 0, 0, 0,   0,   0,   0, 0);
    add(0, 0,  0, 0, 3, 0,  1, 1, 0, 0, 0,   0,   0,   0, 0);
    add(0, 0,  0, 0, 3, 1,  1, 1, 1, 0, 0,   0,   3,  19, 3);
    add(0, 0,  0, 0, 3, 1,  1, 1, 1, 0, 0,  30,   3,  19, 3);
    add(0, 0,  0, 0, 3, 1,  1, 1, 1, 0, 0,  60,  35,  51, 3);
    add(0, 0,  0, 0, 3, 1,  1, 1, 1, 0, 0,  90,  67,  83, 3);
    add(0, 0,  0, 0, 3, 1,  1, 1, 1, 0, 0, 120,  99, 115, 3);
    add(0, 0,  0, 0, 3, 1,  1, 0, 0, 1, 0, 150, 131, 147, 3);
    add(0, 0,  0, 0, 3, 1,  0, 0, 0, 0, 0, 150, 163, 179, 3);
    add(0, 0,  0, 0, 3, 0,  0, 0, 0, 0, 0, 150,   0,   0, 0);
    // Reverse window start=2 count=5, s=0, partial last group.
    add(1, 2,  5, 1, 0, 0,  0, 0, 0, 0, 0, 150,   0,   0, 0);
    add(0, 0,  0, 0, 0, 0,  1, 1, 0, 0, 0,  90,   0,   0, 0);
    add(0, 0,  0, 0, 0, 1,  1, 1, 1, 0, 0,  90,  96,  80, 3);
    add(0, 0,  0, 0, 0, 1,  1, 1, 1, 0, 0,  60,  96,  80, 3);
    add(0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0,  30,  64,  48, 3);
    add(0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0,  30,  32,   0, 1);
    add(0, 0,  0, 0, 0, 1,  1, 0, 0, 1, 0,  30,  32,   0, 1);
    add(0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  30,  32,   0, 1);
    add(0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  30,   0,   0, 0);
    // Rejected kicks: count=0, then start+count past the end (with next_angle).
    add(1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  30,   0,   0, 0);
    add(0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1,  30,   0,   0, 0);
    add(1, 10, 3, 0, 0, 1,  0, 0, 0, 0, 0,  30,   0,   0, 0);
    add(0, 0,  0, 0, 0, 1,  0, 0, 0, 0, 1,  30,   0,   0, 0);
    add(0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  30,   0,   0, 0);
    // Kick wins over next_angle in READY; later kick during WORK is ignored.
    add(1, 4,  4, 0, 0, 1,  0, 0, 0, 0, 0,  30,   0,   0, 0);
    add(0, 0,  0, 0, 0, 0,  1, 1, 0, 0, 0,  60,   0,   0, 0);
    add(1, 0,  2, 1, 1, 0,  1, 1, 0, 0, 0,  60,  64,  80, 3);
    add(0, 0,  0, 0, 2, 0,  1, 1, 0, 0, 0,  60,  65,  81, 3);

    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check_outs(-1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i].kick, int'(vecs[i].start), int'(vecs[i].count), vecs[i].rev,
            int'(vecs[i].s), vecs[i].nxt);
      @(negedge clk);
      check_outs(i, vecs[i].busy, vecs[i].has_next, vecs[i].ack, vecs[i].done, vecs[i].err,
                 int'(vecs[i].ang), int'(vecs[i].a0), int'(vecs[i].a1), int'(vecs[i].vld));
    end

    // s sweep: each address reflects the s driven one cycle earlier.
    for (int s = 3; s <= 15; s++) begin
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0, s, 0);
      @(negedge clk);
      check_outs(100 + s, 1, 1, 0, 0, 0, 60, 64 + s - 1, 80 + s - 1, 3);
    end
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_outs(200, 1, 1, 0, 0, 0, 60, 79, 95, 3);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check_outs(201, 1, 1, 1, 0, 0, 60, 64, 80, 3);

    // Asynchronous reset between edges while in WORK.
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_outs(300, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 5, 1);
    @(negedge clk);
    check_outs(301, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_outs(302, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sinogram_lane_addresser.md
Name: sinogram_lane_addresser

Overview:
- Parametrised successor of the single-angle sinogram addresser.
- Walks a host-configured window of projection angles, forward or reverse, in groups of LANES angles per step.
- Produces one registered sinogram RAM address per lane from the shared filtered-RAM s value, with per-lane valid flags for a partial final group.
- Sits between host control, the filtered RAM swappable (angle handshake) and a LANES-ported sinogram RAM.

Parameters:
NO_OF_ANGLES, 12, total projection angles stored in sinogram RAM
LINE_SIZE, 16, sinogram words per projection line
LANES, 2, angles addressed in parallel per step (>=1)
ANGLE_STEP, 15, angle increment per index, fixed-point angle units
ANGLE_WIDTH, 8, width of angle value and angle index
S_WIDTH, 4, width of s value
ADDR_WIDTH, 8, sinogram address width, >= clog2(NO_OF_ANGLES*LINE_SIZE)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
hs_kick  in  1  start pulse; config sampled on this cycle
hs_start  in  ANGLE_WIDTH  first angle index of window
hs_count  in  ANGLE_WIDTH  number of angles in window
hs_reverse  in  1  0: ascending order, 1: descending from hs_start+hs_count-1
hs_done  out  1  final next-angle request accepted (combinational)
hs_err  out  1  one-cycle registered pulse: kick rejected
hs_busy  out  1  high in WORK
fr_s_val  in  S_WIDTH  s offset within projection line
fr_next_angle  in  1  filtered RAM requests the next angle group
fr_angle  out  ANGLE_WIDTH  angle value of lane 0 (index*ANGLE_STEP)
fr_has_next_angle  out  1  another group remains
fr_next_angle_ack  out  1  request accepted, group advancing
sg_addr  out  LANES*ADDR_WIDTH  lane k address in bits [k*ADDR_WIDTH +: ADDR_WIDTH]
sg_lane_valid  out  LANES  lane k holds a real angle (aligned with sg_addr)

Behaviour:
- clk and reset_n are fixed as stated: one clock, asynchronous active-low reset.
- Reset, applied at any time including mid-WORK, takes immediate effect:
  - state READY
  - fr_angle, idx, rem, base all 0
  - sg_addr 0, sg_lane_valid 0
  - hs_err 0
- States: READY, WORK.
- READY + hs_kick:
  - Rejected if hs_count==0 or hs_start+hs_count > NO_OF_ANGLES. On reject: hs_err pulses the next cycle, state stays READY.
  - Otherwise latch dir=hs_reverse and rem=hs_count.
  - idx = hs_start if forward, hs_start+hs_count-1 if reverse.
  - base = idx*LINE_SIZE.
  - fr_angle = idx*ANGLE_STEP.
  - Go to WORK.
- Ignored inputs: hs_kick in WORK; fr_next_angle in READY (no ack, no done).
- fr_has_next_angle = WORK && rem > LANES.
- fr_next_angle_ack = WORK && fr_next_angle && fr_has_next_angle. On ack, one step advances:
  - idx ±= LANES
  - base ±= LANES*LINE_SIZE
  - fr_angle ±= LANES*ANGLE_STEP
  - rem -= LANES
- hs_done = WORK && fr_next_angle && !fr_has_next_angle. It forces READY the next cycle; registers keep their values.
- Lane k is valid when k < rem.
- Lane k address = base + k*LINE_SIZE + fr_s_val (forward), or base − k*LINE_SIZE + fr_s_val (reverse).
- sg_addr and sg_lane_valid are registered: one-cycle latency from fr_s_val and from the internal state.
- Invalid lanes, and all lanes in READY, output address 0 and valid 0.
- Arithmetic:
  - Unsigned and truncated to ADDR_WIDTH.
  - No wrap occurs for accepted windows.
  - Per-lane offsets k*LINE_SIZE are constants; no run-time multiplier.
  - Updates use accumulators only (no multiply of idx).
- Simultaneous events:
  - hs_kick and fr_next_angle in READY: kick wins, next_angle is ignored.
  - hs_done cycle: the final s values are still addressed. That cycle's registered outputs appear one cycle later, while the state is already READY, and carry the last group.

Test Plan:
1. Default params, kick start=0 count=12 forward, fr_s_val=3:
   - Cycle after next: lane0 addr=3, lane1 addr=19, both valid, fr_angle=0.
   - After 1 ack: lane0 35, lane1 51, fr_angle=30.
   - 5 acks, then the 6th request gives hs_done=1 with ack=0.
2. Kick start=2 count=5 reverse, s=0:
   - First group: lanes 96/80, fr_angle=90.
   - After ack: 64/48.
   - After 2nd ack: lane0=32 valid, lane1=0 invalid, has_next=0.
   - Next request gives hs_done.
3. Kick count=0, then kick start=10 count=3:
   - Each produces an hs_err pulse.
   - State stays READY, hs_busy=0, no acks.
4. Async reset_n low mid-WORK, between clock edges:
   - Outputs go 0 immediately.
   - After release, state is READY.
   - fr_next_angle produces no ack.
5. hs_kick pulsed during WORK with different config: ignored, address sequence unchanged.
6. fr_s_val sweeping 0..15 each cycle (forward, start=4): lane0 addr = 64+s, lane1 addr = 80+s, each appearing exactly one cycle after its s.
